// File: rtl/pixel_frame_sequencer.sv
// Pixel-array frame sequencer: erase -> expose -> convert (Gray ramp) -> read, then streams one buffered frame on AXI-Stream.
// Ports: clk/rst (async, active-high); trigger/continuous/expose_cycles control; erase/expose/convert/read/pixeladdr/ramp_code
//   drive the array; pixel_data is the Gray-coded array return; m_t* is the AXIS master; busy/frame_cnt are status.
// Optional PIXSEQ_TEST_PATTERN_EN adds test_mode: the buffer is filled with the pixel index instead of array data.
// All outputs are registered; latency trigger->erase is one cycle; SEND stalls indefinitely under m_tready=0.
module pixel_frame_sequencer #(
  parameter int ROWS         = 4,
  parameter int COLUMNS      = 4,
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_CYCLES  = 5,
  parameter int ADDR_W       = (ROWS * COLUMNS > 1) ? $clog2(ROWS * COLUMNS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              continuous,
  input  logic [15:0]       expose_cycles,
`ifdef PIXSEQ_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              read,
  output logic [ADDR_W-1:0] pixeladdr,
  output logic [DATA_W-1:0] ramp_code,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int          NPIX       = ROWS * COLUMNS;
  localparam [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NPIX - 1);
  localparam [31:0]       ERASE_LAST = 32'(ERASE_CYCLES - 1);
  localparam [31:0]       READ_LAST  = 32'(READ_CYCLES - 1);
  localparam [31:0]       CONV_LAST  = 32'((64'd1 << DATA_W) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_SEND} state_t;

  state_t              state, state_nxt;
  logic [31:0]         cnt, cnt_nxt;          // cycle count within the current phase / read slot
  logic [ADDR_W-1:0]   idx, idx_nxt;          // pixel index for READ and SEND
  logic [15:0]         exp_len, exp_last;
  logic                latch, frame_done, buf_we;
  logic [DATA_W-1:0]   buf_wdata;
  logic [DATA_W-1:0]   buffer [NPIX];

  logic                erase_d, expose_d, convert_d, read_d, tvalid_d, tlast_d, busy_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   ramp_d, tdata_d;
  logic [15:0]         frame_cnt_d;

  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // An exposure length of 0 behaves as 1
  assign exp_last = (exp_len == 16'd0) ? 16'd0 : exp_len - 16'd1;

`ifdef PIXSEQ_TEST_PATTERN_EN
  logic                     test_q;
  logic [ADDR_W+DATA_W-1:0] idx_ext;
  assign idx_ext = {{DATA_W{1'b0}}, idx};
`endif

  always_comb begin
    buf_wdata = gray2bin(pixel_data);
`ifdef PIXSEQ_TEST_PATTERN_EN
    if (test_q) buf_wdata = idx_ext[DATA_W-1:0];
`endif
  end

  // State, phase counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      exp_len   <= '0;
      erase     <= 1'b0;
      expose    <= 1'b0;
      convert   <= 1'b0;
      read      <= 1'b0;
      pixeladdr <= '0;
      ramp_code <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
`ifdef PIXSEQ_TEST_PATTERN_EN
      test_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      if (latch) exp_len <= expose_cycles;
`ifdef PIXSEQ_TEST_PATTERN_EN
      if (latch) test_q <= test_mode;
`endif
      erase     <= erase_d;
      expose    <= expose_d;
      convert   <= convert_d;
      read      <= read_d;
      pixeladdr <= addr_d;
      ramp_code <= ramp_d;
      m_tvalid  <= tvalid_d;
      m_tdata   <= tdata_d;
      m_tlast   <= tlast_d;
      busy      <= busy_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  // Frame buffer: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (buf_we) buffer[idx] <= buf_wdata;
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 32'd1;
    idx_nxt    = idx;
    latch      = 1'b0;
    frame_done = 1'b0;
    buf_we     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (trigger) begin
          state_nxt = S_ERASE;
          latch     = 1'b1;
        end
      end
      S_ERASE: if (cnt == ERASE_LAST) begin
        state_nxt = S_EXPOSE;
        cnt_nxt   = '0;
      end
      S_EXPOSE: if (cnt == {16'd0, exp_last}) begin
        state_nxt = S_CONVERT;
        cnt_nxt   = '0;
      end
      S_CONVERT: if (cnt == CONV_LAST) begin
        state_nxt = S_READ;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
      S_READ: if (cnt == READ_LAST) begin
        buf_we  = 1'b1;
        cnt_nxt = '0;
        if (idx == LAST_PIX) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      S_SEND: begin
        cnt_nxt = '0;
        if (m_tvalid && m_tready) begin
          if (idx == LAST_PIX) begin
            frame_done = 1'b1;
            idx_nxt    = '0;
            if (continuous) begin
              state_nxt = S_ERASE;
              latch     = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            idx_nxt = idx + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computed from the next state so every registered output lines up with its state
  always_comb begin
    erase_d     = (state_nxt == S_ERASE);
    expose_d    = (state_nxt == S_EXPOSE);
    convert_d   = (state_nxt == S_CONVERT);
    read_d      = (state_nxt == S_READ);
    busy_d      = (state_nxt != S_IDLE);
    tvalid_d    = (state_nxt == S_SEND);
    ramp_d      = convert_d ? (cnt_nxt[DATA_W-1:0] ^ (cnt_nxt[DATA_W-1:0] >> 1)) : '0;
    addr_d      = read_d ? idx_nxt : '0;
    tdata_d     = '0;
    tlast_d     = 1'b0;
    if (tvalid_d) begin
      // Bypass covers a single-pixel frame, where the only write lands on the same edge as the first read
      tdata_d = (buf_we && (idx_nxt == idx)) ? buf_wdata : buffer[idx_nxt];
      tlast_d = (idx_nxt == LAST_PIX);
    end
    frame_cnt_d = frame_done ? frame_cnt + 16'd1 : frame_cnt;
  end

endmodule
